math_game_core: RTL

Parametrised successor to the five-operand mental-arithmetic game. It runs a multi-round session with a configurable operand count, operand width, slot length and round count. Operands come from a seedable LFSR and are flashed one at a time on the two-digit display; the player's answer is scored per round. It sits between board I/O (switches, buttons, LEDs, 7-segment decoders) and owns all game sequencing.

---
 rtl/math_game_pkg.sv | 43 ++++
 rtl/lfsr_n.sv | 36 +++
 rtl/math_game_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/math_game_pkg.sv
// Shared types, constants and helpers for the math game core and its LFSR.
package math_game_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StShow   = 3'd1,
      StThink  = 3'd2,
      StAnswer = 3'd3,
      StReveal = 3'd4,
      StOver   = 3'd5
   } state_e;

   localparam int unsigned BcdMax = 99;

   // Ceiling log2, never less than 1 so derived vectors are always legal.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   // Maximal-length feedback taps for widths 4..8, as a bit mask.
   function automatic logic [7:0] lfsr_taps(input int unsigned w);
      case (w)
         4:       return 8'h0C;
         5:       return 8'h14;
         6:       return 8'h30;
         7:       return 8'h60;
         default: return 8'hB8;
      endcase
   endfunction

   function automatic logic [6:0] thermo7(input int unsigned n);
      logic [6:0] t;
      t = '0;
      for (int unsigned i = 0; i < 7; i++) begin
         if (i < n) t[i] = 1'b1;
      end
      return t;
   endfunction

endpackage

// File: rtl/lfsr_n.sv
// Fibonacci shift-left LFSR with seed load, single-step advance and zero-seed guard.
module lfsr_n
   import math_game_pkg::*;
#(
   parameter int unsigned Width = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [Width-1:0] seed_i,
   input  logic             advance_i,
   output logic [Width-1:0] next_o
);

   localparam logic [Width-1:0] Taps = Width'(lfsr_taps(Width));

   logic [Width-1:0] lfsr_q, lfsr_d;

   assign next_o = {lfsr_q[Width-2:0], ^(lfsr_q & Taps)};

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         // An all-zero state would lock up, so zero seeds become 1.
         lfsr_d = (seed_i == '0) ? Width'(1) : seed_i;
      end else if (advance_i) begin
         lfsr_d = next_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= Width'(1);
      else        lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/math_game_core.sv
// Multi-round mental-arithmetic game sequencer with scoring and BCD display output.
// Define MATHGAME_SUB_MODE_EN to subtract odd-indexed operands.
module math_game_core
   import math_game_pkg::*;
#(
   parameter int unsigned N_OPERANDS   = 5,
   parameter int unsigned OP_W         = 5,
   parameter int unsigned TICKS        = 10,
   parameter int unsigned ANSWER_TICKS = 40,
   parameter int unsigned N_ROUNDS     = 8,
   parameter int unsigned MOD          = 100
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [OP_W-1:0]                  seed,
   input  logic [7:0]                       answer,
   input  logic                             answer_valid,
   output logic [7:0]                       display,
   output logic [3:0]                       bcd_tens,
   output logic [3:0]                       bcd_units,
   output logic [6:0]                       led,
   output logic [clog2(N_ROUNDS+1)-1:0]     score,
   output logic [3:0]                       round_idx,
   output logic [2:0]                       state,
   output logic                             game_over
);

   localparam int unsigned SCORE_W  = clog2(N_ROUNDS + 1);
   localparam int unsigned ACC_W    = OP_W + clog2(N_OPERANDS) + 1;
   localparam int unsigned SLOT_W   = clog2(N_OPERANDS);
   localparam int unsigned MaxTicks = (TICKS > ANSWER_TICKS) ? TICKS : ANSWER_TICKS;
   localparam int unsigned TICK_W   = clog2(MaxTicks);
   localparam int          ModS     = int'(MOD);

   state_e                   state_q, state_d;
   logic [TICK_W-1:0]        tick_q, tick_d;
   logic [SLOT_W-1:0]        slot_q, slot_d;
   logic [3:0]               round_q, round_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next, acc_base, op_acc;
   logic [SCORE_W-1:0]       score_q, score_d;
   logic                     correct_q, correct_d;
   logic [7:0]               display_q, display_d;
   logic [3:0]               tens_q, tens_d, units_q, units_d;
   logic [6:0]               led_q, led_d;
   logic                     game_over_q, game_over_d;
   logic                     lfsr_load, lfsr_adv;
   logic [OP_W-1:0]          operand;
   logic signed [31:0]       rem;
   logic [7:0]               result;
   logic [7:0]               clamp;
   logic                     tick_last, answer_last, slot_last, round_last;

   lfsr_n #(
      .Width (OP_W)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (lfsr_load),
      .seed_i    (seed),
      .advance_i (lfsr_adv),
      .next_o    (operand)
   );

   assign tick_last   = (tick_q == TICK_W'(TICKS - 1));
   assign answer_last = (tick_q == TICK_W'(ANSWER_TICKS - 1));
   assign slot_last   = (slot_q == SLOT_W'(N_OPERANDS - 1));
   assign round_last  = (round_q == 4'(N_ROUNDS - 1));

   // Slot 0 starts from zero, so each round's sum begins fresh.
   always_comb begin
      op_acc   = ACC_W'(operand);
      acc_base = (slot_q == '0) ? '0 : acc_q;
`ifdef MATHGAME_SUB_MODE_EN
      acc_next = slot_q[0] ? (acc_base - op_acc) : (acc_base + op_acc);
`else
      acc_next = acc_base + op_acc;
`endif
   end

   always_comb begin
      rem = 32'(acc_q) % ModS;
`ifdef MATHGAME_SUB_MODE_EN
      if (rem < 0) rem = rem + ModS;
`endif
      result = 8'(rem);
   end

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      slot_d      = slot_q;
      round_d     = round_q;
      acc_d       = acc_q;
      score_d     = score_q;
      correct_d   = correct_q;
      display_d   = display_q;
      led_d       = '0;
      lfsr_load   = 1'b0;
      lfsr_adv    = 1'b0;

      unique case (state_q)
         StIdle: display_d = '0;
         StShow: begin
            if (tick_q == '0) begin
               lfsr_adv  = 1'b1;
               display_d = 8'(operand);
               acc_d     = acc_next;
            end
            if (tick_last) begin
               tick_d = '0;
               if (slot_last) state_d = StThink;
               else           slot_d  = slot_q + SLOT_W'(1);
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         StThink: begin
            display_d = '0;
            if (tick_last) begin
               tick_d  = '0;
               state_d = StAnswer;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         StAnswer: begin
            display_d = answer;
            if (answer_valid) begin
               correct_d = (answer == result);
               tick_d    = '0;
               state_d   = StReveal;
            end else if (answer_last) begin
               correct_d = 1'b0;
               tick_d    = '0;
               state_d   = StReveal;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         StReveal: begin
            display_d = result;
            led_d     = correct_q ? 7'h7F : 7'h00;
            if ((tick_q == '0) && correct_q && (score_q != SCORE_W'(N_ROUNDS))) begin
               score_d = score_q + SCORE_W'(1);
            end
            if (tick_last) begin
               tick_d = '0;
               if (round_last) begin
                  state_d = StOver;
               end else begin
                  round_d = round_q + 4'd1;
                  slot_d  = '0;
                  acc_d   = '0;
                  state_d = StShow;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         StOver: begin
            display_d = 8'(score_q);
            led_d     = thermo7(32'(score_q));
         end
         default: state_d = StIdle;
      endcase

      if (((state_q == StIdle) || (state_q == StOver)) && start) begin
         lfsr_load = 1'b1;
         state_d   = StShow;
         tick_d    = '0;
         slot_d    = '0;
         round_d   = '0;
         acc_d     = '0;
         score_d   = '0;
         correct_d = 1'b0;
      end

      game_over_d = (state_d == StOver);
   end

   always_comb begin
      clamp   = (display_d > 8'(BcdMax)) ? 8'(BcdMax) : display_d;
      tens_d  = 4'(clamp / 8'd10);
      units_d = 4'(clamp % 8'd10);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         tick_q      <= '0;
         slot_q      <= '0;
         round_q     <= '0;
         acc_q       <= '0;
         score_q     <= '0;
         correct_q   <= 1'b0;
         display_q   <= '0;
         tens_q      <= '0;
         units_q     <= '0;
         led_q       <= '0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         slot_q      <= slot_d;
         round_q     <= round_d;
         acc_q       <= acc_d;
         score_q     <= score_d;
         correct_q   <= correct_d;
         display_q   <= display_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         led_q       <= led_d;
         game_over_q <= game_over_d;
      end
   end

   assign display   = display_q;
   assign bcd_tens  = tens_q;
   assign bcd_units = units_q;
   assign led       = led_q;
   assign score     = score_q;
   assign round_idx = round_q;
   assign state     = state_q;
   assign game_over = game_over_q;

endmodule
